// File: rtl/axi_master_wrapper_pkg.sv
// -----------------------------------------------------------------------------
// axi_master_wrapper_pkg
// Shared definitions for the host-request to AXI4-Lite master bridge:
//   - default bus widths
//   - FSM state encoding
//   - AXI response codes and a response-decode helper
// -----------------------------------------------------------------------------
package axi_master_wrapper_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Any response other than OKAY is reported to the host as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_master_wrapper_if.sv
// -----------------------------------------------------------------------------
// axi_master_wrapper_if
// AXI4-Lite channel bundle between the bridge (master) and the shared memory
// block (slave).
//   AW: awaddr, awvalid / awready
//   W : wdata, wstrb, wvalid / wready
//   B : bresp, bvalid / bready
//   AR: araddr, arvalid / arready
//   R : rdata, rresp, rvalid / rready
// -----------------------------------------------------------------------------
interface axi_master_wrapper_if
  import axi_master_wrapper_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_master_wrapper.sv
// -----------------------------------------------------------------------------
// axi_master_wrapper
// Bridges a simple host request port to an AXI4-Lite master. One single-beat
// read or write in flight at a time; requests arriving while busy are dropped.
// Ports:
//   clk, nreset      clock, asynchronous active-low reset
//   si_valid         request strobe (taken only in IDLE)
//   si_write         1 = write, 0 = read
//   si_addr/si_wdata byte address / write data
//   so_busy          transaction in progress
//   so_done          one-cycle completion pulse
//   so_data          last read data, held until the next read completes
//   so_err           last response was not OKAY, held until the next completion
//   m                AXI4-Lite master modport
// All host and AXI control outputs come straight from flops.
// -----------------------------------------------------------------------------
module axi_master_wrapper
  import axi_master_wrapper_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   si_valid,
  input  logic                   si_write,
  input  logic [AW-1:0]          si_addr,
  input  logic [DW-1:0]          si_wdata,
  output logic                   so_busy,
  output logic                   so_done,
  output logic [DW-1:0]          so_data,
  output logic                   so_err,
  axi_master_wrapper_if.master   m
);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic            awvalid_r;
  logic            wvalid_r;
  logic            arvalid_r;
  logic            bready_r;
  logic            rready_r;
  logic            busy_r;
  logic            done_r;
  logic [DW-1:0]   data_r;
  logic            err_r;
  logic            accept_s;
  logic            aw_fire_s;
  logic            w_fire_s;

  assign accept_s  = (state_r == IDLE) & si_valid;
  assign aw_fire_s = awvalid_r & m.awready;
  assign w_fire_s  = wvalid_r & m.wready;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; the write phase ends once each channel has either
  // already handshaken (valid dropped) or is handshaking this cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (si_valid) begin
          state_nxt_s = si_write ? WR : RD_A;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR: begin
        if ((!awvalid_r || m.awready) && (!wvalid_r || m.wready)) begin
          state_nxt_s = WR_B;
        end else begin
          state_nxt_s = WR;
        end
      end
      WR_B: begin
        if (m.bvalid) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WR_B;
        end
      end
      RD_A: begin
        if (m.arready) begin
          state_nxt_s = RD_D;
        end else begin
          state_nxt_s = RD_A;
        end
      end
      RD_D: begin
        if (m.rvalid) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RD_D;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request capture; only loaded in IDLE so address/data stay stable while valid
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
    end else if (accept_s) begin
      addr_r  <= si_addr;
      wdata_r <= si_wdata;
    end
  end

  // AW/W valids: raised together on accept, each cleared after its own handshake
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
    end else if (accept_s && si_write) begin
      awvalid_r <= 1'b1;
      wvalid_r  <= 1'b1;
    end else begin
      if (aw_fire_s) begin
        awvalid_r <= 1'b0;
      end
      if (w_fire_s) begin
        wvalid_r <= 1'b0;
      end
    end
  end

  // Per-state control outputs, registered from the next state
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      arvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      rready_r  <= 1'b0;
    end else begin
      busy_r    <= (state_nxt_s == WR) || (state_nxt_s == WR_B) ||
                   (state_nxt_s == RD_A) || (state_nxt_s == RD_D);
      done_r    <= (state_nxt_s == DONE);
      arvalid_r <= (state_nxt_s == RD_A);
      bready_r  <= (state_nxt_s == WR_B);
      rready_r  <= (state_nxt_s == RD_D);
    end
  end

  // Completion status; responses outside WR_B/RD_D are not accepted
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      data_r <= {DW{1'b0}};
      err_r  <= 1'b0;
    end else if ((state_r == WR_B) && m.bvalid) begin
      err_r  <= resp_is_err(m.bresp);
    end else if ((state_r == RD_D) && m.rvalid) begin
      data_r <= m.rdata;
      err_r  <= resp_is_err(m.rresp);
    end
  end

  assign m.awaddr  = addr_r;
  assign m.awvalid = awvalid_r;
  assign m.wdata   = wdata_r;
  assign m.wstrb   = {(DW/8){1'b1}};
  assign m.wvalid  = wvalid_r;
  assign m.bready  = bready_r;
  assign m.araddr  = addr_r;
  assign m.arvalid = arvalid_r;
  assign m.rready  = rready_r;

  assign so_busy = busy_r;
  assign so_done = done_r;
  assign so_data = data_r;
  assign so_err  = err_r;

endmodule

// File: tb/tb_axi_master_wrapper.sv
// -----------------------------------------------------------------------------
// tb_axi_master_wrapper
// Directed bench for axi_master_wrapper with a small AXI4-Lite memory model.
// Expected completions are queued when a request is issued; a negedge monitor
// pops and compares on every so_done pulse.
// -----------------------------------------------------------------------------
module tb_axi_master_wrapper;
  import axi_master_wrapper_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          si_valid = 1'b0;
  logic          si_write = 1'b0;
  logic [AW-1:0] si_addr = 8'h00;
  logic [DW-1:0] si_wdata = 32'h0;
  logic          so_busy;
  logic          so_done;
  logic [DW-1:0] so_data;
  logic          so_err;

  always #5 clk = ~clk;

  axi_master_wrapper_if #(.AW(AW), .DW(DW)) bus ();

  axi_master_wrapper #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .si_valid (si_valid),
    .si_write (si_write),
    .si_addr  (si_addr),
    .si_wdata (si_wdata),
    .so_busy  (so_busy),
    .so_done  (so_done),
    .so_data  (so_data),
    .so_err   (so_err),
    .m        (bus.master)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  int          aw_cnt;
  int          aw_delay = 0;
  logic        b_hold = 1'b0;
  logic [1:0]  wr_resp = RESP_OKAY;
  logic [1:0]  rd_resp = RESP_OKAY;
  logic        rd_force = 1'b0;
  logic [31:0] rd_force_data = 32'h0;
  logic        aw_got, w_got;
  logic [7:0]  aw_q;
  logic [31:0] w_q;
  logic [3:0]  strb_q;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid;
  assign bus.arready = bus.arvalid;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      aw_cnt     <= 0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_q       <= 8'h0;
      w_q        <= 32'h0;
      strb_q     <= 4'h0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.rvalid <= 1'b0;
      bus.rresp  <= 2'b00;
      bus.rdata  <= 32'h0;
    end else begin
      if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (bus.awvalid && bus.awready) begin
        aw_got <= 1'b1;
        aw_q   <= bus.awaddr;
      end
      if (bus.wvalid && bus.wready) begin
        w_got  <= 1'b1;
        w_q    <= bus.wdata;
        strb_q <= bus.wstrb;
      end
      if (aw_got && w_got && !bus.bvalid && !b_hold) begin
        mem[aw_q[7:2]] <= w_q;
        bus.bvalid     <= 1'b1;
        bus.bresp      <= wr_resp;
        aw_got         <= 1'b0;
        w_got          <= 1'b0;
      end else if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rd_force ? rd_force_data : mem[bus.araddr[7:2]];
        bus.rresp  <= rd_resp;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (so_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 64'(so_done), 64'(0));
      end else begin
        chk("done_err",  64'(so_err),  64'(sb_q[0].err));
        chk("done_data", 64'(so_data), 64'(sb_q[0].data));
        chk("done_busy", 64'(so_busy), 64'(0));
        void'(sb_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while ((so_busy || so_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'(1), 64'(0));
    si_valid = 1'b1;
    si_write = wr;
    si_addr  = a;
    si_wdata = d;
    @(negedge clk);
    si_valid = 1'b0;
    si_write = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = so_done;
      n++;
    end
    if (!seen) chk("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: reset
    nreset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_host", 64'({so_busy, so_done, so_err}), 64'(0));
    chk("rst_data", 64'(so_data), 64'(0));
    chk("rst_axi_ctl", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}), 64'(0));
    chk("rst_addr_wdata", 64'({bus.awaddr, bus.wdata}), 64'(0));
    chk("rst_state", 64'(dut.state_r), 64'(IDLE));
    nreset = 1'b1;

    // 2: write 0xB4B4B4B4 to address 0
    sb_q.push_back('{err: 1'b0, data: 32'h0});
    issue(1'b1, 8'h00, 32'hB4B4_B4B4);
    chk("t2_valids", 64'({bus.awvalid, bus.wvalid, so_busy}), 64'(3'b111));
    chk("t2_wstrb", 64'(bus.wstrb), 64'(4'hF));
    chk("t2_wdata", 64'(bus.wdata), 64'(32'hB4B4_B4B4));
    wait_done();
    chk("t2_mem0", 64'(mem[0]), 64'(32'hB4B4_B4B4));
    chk("t2_strb_seen", 64'(strb_q), 64'(4'hF));

    // 3: read back address 0; a request while busy must be dropped
    sb_q.push_back('{err: 1'b0, data: 32'hB4B4_B4B4});
    issue(1'b0, 8'h00, 32'h0);
    si_valid = 1'b1;
    si_write = 1'b1;
    @(negedge clk);
    si_valid = 1'b0;
    si_write = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("t3_no_queue_busy", 64'(so_busy), 64'(0));
    chk("t3_done_count", 64'(done_cnt), 64'(2));

    // 4: awready three cycles late, wready immediate
    aw_delay = 3;
    sb_q.push_back('{err: 1'b0, data: 32'hB4B4_B4B4});
    issue(1'b1, 8'h04, 32'h1234_5678);
    chk("t4_both_valid", 64'({bus.awvalid, bus.wvalid}), 64'(2'b11));
    @(negedge clk);
    chk("t4_w_drops_first", 64'({bus.awvalid, bus.wvalid}), 64'(2'b10));
    n = 0;
    while (bus.awvalid && n < 20) begin
      chk("t4_awaddr_stable", 64'(bus.awaddr), 64'(8'h04));
      @(negedge clk);
      n++;
    end
    chk("t4_aw_stall", 64'(n), 64'(3));
    n = 0;
    while (!(bus.bvalid && bus.bready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_b_seen", 64'(bus.bvalid && bus.bready), 64'(1));
    @(negedge clk);
    chk("t4_done_after_b", 64'(so_done), 64'(1));
    aw_delay = 0;
    chk("t4_mem1", 64'(mem[1]), 64'(32'h1234_5678));

    // 5: SLVERR read, then an OKAY write clears so_err; so_data is held
    rd_resp = RESP_SLVERR;
    rd_force = 1'b1;
    rd_force_data = 32'hDEAD_BEEF;
    sb_q.push_back('{err: 1'b1, data: 32'hDEAD_BEEF});
    issue(1'b0, 8'h08, 32'h0);
    wait_done();
    rd_resp = RESP_OKAY;
    rd_force = 1'b0;
    sb_q.push_back('{err: 1'b0, data: 32'hDEAD_BEEF});
    issue(1'b1, 8'h0C, 32'hA5A5_0F0F);
    wait_done();
    // request presented during DONE is ignored
    si_valid = 1'b1;
    si_write = 1'b0;
    @(negedge clk);
    si_valid = 1'b0;
    @(negedge clk);
    chk("t5_done_ignores_valid", 64'(so_busy), 64'(0));

    // 6: reset while waiting for the write response
    b_hold = 1'b1;
    issue(1'b1, 8'h10, 32'h1111_1111);
    n = 0;
    while (!bus.bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_wr_b", 64'(bus.bready), 64'(1));
    #2 nreset = 1'b0;
    #1;
    chk("t6_async_ctl", 64'({so_busy, so_done, so_err, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}), 64'(0));
    chk("t6_async_data", 64'({so_data, bus.awaddr}), 64'(0));
    b_hold = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    sb_q.push_back('{err: 1'b0, data: 32'h0});
    issue(1'b1, 8'h10, 32'h2222_2222);
    wait_done();
    chk("t6_mem4", 64'(mem[4]), 64'(32'h2222_2222));

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    chk("done_total", 64'(done_cnt), 64'(6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
